// File: rtl/conv1d_pkg.sv
// Shared types and constants for the 1-D convolution feed sequencer.
package conv1d_pkg;

  // Width of tap counts and of the active PE count handed to the conv top.
  localparam int unsigned PE_CNT_W = 5;

  // Sample value used for the flush beats that push the last real samples through.
  localparam logic [63:0] ZERO_SAMPLE = '0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_K,
    STREAM,
    FLUSH,
    DRAIN
  } state_e;

endpackage

// File: rtl/conv1d_seq_counter.sv
// Loadable down-counter with a zero flag; saturates at zero instead of wrapping.
module conv1d_seq_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: a load wins over a decrement; a decrement at zero is ignored.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/conv1d_feed_sequencer.sv
// Feeds kernel taps and samples into the 1-D systolic convolution top, then flushes and drains.
module conv1d_feed_sequencer
  import conv1d_pkg::*;
#(
  parameter int unsigned NUM_PE       = 16,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned LEN_WIDTH    = 16,
  parameter int unsigned DRAIN_CYCLES = 18
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_start,
  input  logic [PE_CNT_W-1:0]   cfg_pe_count,
  input  logic [LEN_WIDTH-1:0]  cfg_seq_len,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_error,
  input  logic                  k_valid,
  output logic                  k_ready,
  input  logic [DATA_WIDTH-1:0] k_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic [PE_CNT_W-1:0]   conv_active_pe_count,
  output logic                  conv_kernel_load,
  output logic [DATA_WIDTH-1:0] conv_kernel_value,
  output logic [DATA_WIDTH-1:0] conv_x_in,
  output logic                  conv_x_valid
);

  // Drain counter holds DRAIN_CYCLES-1 down to 0.
  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e state_q, state_d;

  logic                  cfg_legal;
  logic                  accept;
  logic                  reject;
  logic                  k_hs;
  logic                  s_hs;
  logic                  tap_zero;
  logic                  sample_zero;
  logic                  flush_zero;
  logic                  drain_zero;
  logic                  drain_done;

  logic [PE_CNT_W-1:0]   pe_count_q;
  logic                  cfg_error_q;
  logic [PE_CNT_W-1:0]   active_q;
  logic                  kernel_load_q;
  logic [DATA_WIDTH-1:0] kernel_value_q;
  logic                  x_valid_q;
  logic [DATA_WIDTH-1:0] x_in_q;

  assign cfg_legal = (cfg_pe_count != '0) && (cfg_pe_count <= PE_CNT_W'(NUM_PE)) &&
                     (cfg_seq_len != '0);
  assign accept    = (state_q == IDLE) && cfg_start && cfg_legal;
  assign reject    = (state_q == IDLE) && cfg_start && !cfg_legal;
  assign k_hs      = k_valid && (state_q == LOAD_K);
  assign s_hs      = s_valid && (state_q == STREAM);

  // Drain only counts cycles whose output beat is already idle, so the last real or
  // flush beat is followed by exactly DRAIN_CYCLES quiet cycles before done.
  assign drain_done = (state_q == DRAIN) && drain_zero && !x_valid_q;

  // All counters load at start accept; each holds "beats remaining after this one".
  conv1d_seq_counter #(
    .WIDTH (PE_CNT_W)
  ) u_tap_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .load_value (cfg_pe_count - 1'b1),
    .dec        (k_hs),
    .zero       (tap_zero)
  );

  conv1d_seq_counter #(
    .WIDTH (LEN_WIDTH)
  ) u_sample_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .load_value (cfg_seq_len - 1'b1),
    .dec        (s_hs),
    .zero       (sample_zero)
  );

  // For pe_count == 1 the loaded value wraps but FLUSH is never entered.
  conv1d_seq_counter #(
    .WIDTH (PE_CNT_W)
  ) u_flush_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .load_value (cfg_pe_count - PE_CNT_W'(2)),
    .dec        (state_q == FLUSH),
    .zero       (flush_zero)
  );

  conv1d_seq_counter #(
    .WIDTH (DRAIN_W)
  ) u_drain_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .load_value (DRAIN_W'(DRAIN_CYCLES - 1)),
    .dec        ((state_q == DRAIN) && !x_valid_q),
    .zero       (drain_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = LOAD_K;
      LOAD_K:  if (k_hs && tap_zero) state_d = STREAM;
      STREAM: begin
        if (s_hs && sample_zero) begin
          state_d = (pe_count_q > PE_CNT_W'(1)) ? FLUSH : DRAIN;
        end
      end
      FLUSH:   if (flush_zero) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Combinational outputs decoded from the current state.
  always_comb begin
    busy    = (state_q != IDLE);
    k_ready = (state_q == LOAD_K);
    s_ready = (state_q == STREAM);
    done    = drain_done;
  end

  // Registered datapath outputs and latched configuration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pe_count_q     <= '0;
      cfg_error_q    <= 1'b0;
      active_q       <= PE_CNT_W'(NUM_PE);
      kernel_load_q  <= 1'b0;
      kernel_value_q <= '0;
      x_valid_q      <= 1'b0;
      x_in_q         <= '0;
    end else begin
      cfg_error_q   <= reject;
      kernel_load_q <= k_hs;
      x_valid_q     <= s_hs || (state_q == FLUSH);
      if (accept) begin
        pe_count_q <= cfg_pe_count;
        active_q   <= cfg_pe_count;
      end
      if (k_hs) begin
        kernel_value_q <= k_data;
      end
      if (s_hs) begin
        x_in_q <= s_data;
      end else if (state_q == FLUSH) begin
        x_in_q <= ZERO_SAMPLE[DATA_WIDTH-1:0];
      end
    end
  end

  assign cfg_error            = cfg_error_q;
  assign conv_active_pe_count = active_q;
  assign conv_kernel_load     = kernel_load_q;
  assign conv_kernel_value    = kernel_value_q;
  assign conv_x_valid         = x_valid_q;
  assign conv_x_in            = x_in_q;

endmodule
